// File: rtl/scsi_port_sm_pkg.sv
// scsi_port_sm_pkg: shared state encoding and default strobe length for the SCSI port sequencer
package scsi_port_sm_pkg;
  typedef enum logic [2:0] {IDLE, CPU_STB, CPU_ACK, DMA_STB, DMA_LATCH, DMA_WAIT} state_t;
  localparam int STROBE_CYC_DEF = 3;
endpackage

// File: rtl/scsi_port_sm.sv
// scsi_port_sm: WD33C93A strobe sequencer serving CPU register accesses and DMA byte transfers
// Ports: CLK/RST (sync, active high); CPUREQ/RW/AS_ CPU access request; DMADIR/DREQ_ DMA request;
// FIFOFULL/FIFOEMPTY/BOEQ3 FIFO status; INCFIFO/DECFIFO CPU-side acks;
// SCSI_CS_o/RE_o/WE_o/DACK_o chip strobes; S2F_o/F2S_o/S2CPU_o/CPU2S_o datapath steering;
// LBYTE_/LS2CPU active-low latch/ack; INCBO_o/INCNI_o/INCNO_o pointer pulses; RIFIFO_o/RDFIFO_o count requests.
module scsi_port_sm
  import scsi_port_sm_pkg::*;
#(
  parameter int STROBE_CYC = STROBE_CYC_DEF
) (
  input  logic CLK,
  input  logic RST,
  input  logic CPUREQ,
  input  logic RW,
  input  logic AS_,
  input  logic DMADIR,
  input  logic DREQ_,
  input  logic FIFOFULL,
  input  logic FIFOEMPTY,
  input  logic BOEQ3,
  input  logic INCFIFO,
  input  logic DECFIFO,
  output logic SCSI_CS_o,
  output logic RE_o,
  output logic WE_o,
  output logic DACK_o,
  output logic S2F_o,
  output logic F2S_o,
  output logic S2CPU_o,
  output logic CPU2S_o,
  output logic LBYTE_,
  output logic LS2CPU,
  output logic INCBO_o,
  output logic INCNI_o,
  output logic INCNO_o,
  output logic RIFIFO_o,
  output logic RDFIFO_o
);
  localparam int CW = $clog2(STROBE_CYC);
  localparam logic [CW-1:0] LAST = CW'(STROBE_CYC - 1);
  state_t r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic r_rw, r_dir, r_bo3, r_rififo, r_rdfifo;
  logic w_stb, w_dma_ok, w_set_ri, w_set_rd;
  // rw/dir are captured while idle so the steering stays stable for the whole cycle
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_rw     <= 1'b0;
      r_dir    <= 1'b0;
      r_bo3    <= 1'b0;
      r_rififo <= 1'b0;
      r_rdfifo <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_cnt    <= (w_stb && w_next == r_state) ? r_cnt + CW'(1) : '0;
      r_rw     <= (r_state == IDLE) ? RW : r_rw;
      r_dir    <= (r_state == IDLE) ? DMADIR : r_dir;
      r_bo3    <= (r_state == DMA_STB) ? BOEQ3 : r_bo3;
      r_rififo <= w_set_ri | (r_rififo & ~INCFIFO);
      r_rdfifo <= w_set_rd | (r_rdfifo & ~DECFIFO);
    end
  end
  assign w_stb    = (r_state == CPU_STB) || (r_state == DMA_STB);
  assign w_dma_ok = ~DREQ_ & ((DMADIR & ~FIFOFULL) | (~DMADIR & ~FIFOEMPTY)) & ~r_rififo & ~r_rdfifo;
  assign w_set_ri = (r_state == DMA_LATCH) & r_dir & r_bo3;
  assign w_set_rd = (r_state == DMA_LATCH) & ~r_dir & r_bo3;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      w_next = (CPUREQ & ~AS_) ? CPU_STB : w_dma_ok ? DMA_STB : IDLE;
      CPU_STB:   w_next = (r_cnt == LAST) ? CPU_ACK : CPU_STB;
      CPU_ACK:   w_next = (AS_ & ~CPUREQ) ? IDLE : CPU_ACK;
      DMA_STB:   w_next = (r_cnt == LAST) ? DMA_LATCH : DMA_STB;
      DMA_LATCH: w_next = DMA_WAIT;
      default:   w_next = IDLE;
    endcase
  end
  assign SCSI_CS_o = r_state == CPU_STB;
  assign RE_o      = ((r_state == CPU_STB) & r_rw) | ((r_state == DMA_STB) & r_dir);
  assign WE_o      = ((r_state == CPU_STB) & ~r_rw) | ((r_state == DMA_STB) & ~r_dir);
  assign DACK_o    = (r_state == DMA_STB) || (r_state == DMA_LATCH);
  assign S2F_o     = DACK_o & r_dir;
  assign F2S_o     = DACK_o & ~r_dir;
  assign S2CPU_o   = ((r_state == CPU_STB) || (r_state == CPU_ACK)) & r_rw;
  assign CPU2S_o   = (r_state == CPU_STB) & ~r_rw;
  assign LBYTE_    = ~((r_state == DMA_LATCH) & r_dir);
  assign LS2CPU    = r_state != CPU_ACK;
  assign INCBO_o   = r_state == DMA_LATCH;
  assign INCNI_o   = w_set_ri;
  assign INCNO_o   = w_set_rd;
  assign RIFIFO_o  = r_rififo;
  assign RDFIFO_o  = r_rdfifo;
endmodule

// File: tb/tb_scsi_port_sm.sv
// tb_scsi_port_sm: scoreboard bench for scsi_port_sm comparing per-cycle output words
module tb_scsi_port_sm;
  localparam logic [14:0] CS = 15'h4000, RE = 15'h2000, WE = 15'h1000, DK = 15'h0800,
    S2F = 15'h0400, F2S = 15'h0200, S2C = 15'h0100, C2S = 15'h0080, LB = 15'h0040,
    LC = 15'h0020, IBO = 15'h0010, INI = 15'h0008, INO = 15'h0004, RIF = 15'h0002, RDF = 15'h0001;
  localparam logic [14:0] IDL = LB | LC;
  logic CLK = 1'b0, RST = 1'b1;
  logic CPUREQ = 1'b0, RW = 1'b0, AS_ = 1'b1, DMADIR = 1'b0, DREQ_ = 1'b1;
  logic FIFOFULL = 1'b0, FIFOEMPTY = 1'b0, BOEQ3 = 1'b0, INCFIFO = 1'b0, DECFIFO = 1'b0;
  logic SCSI_CS_o, RE_o, WE_o, DACK_o, S2F_o, F2S_o, S2CPU_o, CPU2S_o, LBYTE_, LS2CPU;
  logic INCBO_o, INCNI_o, INCNO_o, RIFIFO_o, RDFIFO_o;
  logic [14:0] w_o;
  int n_tests = 0, n_fail = 0;
  string q_tag[$];
  logic [14:0] q_exp[$];
  always #5 CLK = ~CLK;
  scsi_port_sm dut (
    .CLK(CLK), .RST(RST), .CPUREQ(CPUREQ), .RW(RW), .AS_(AS_), .DMADIR(DMADIR), .DREQ_(DREQ_),
    .FIFOFULL(FIFOFULL), .FIFOEMPTY(FIFOEMPTY), .BOEQ3(BOEQ3), .INCFIFO(INCFIFO), .DECFIFO(DECFIFO),
    .SCSI_CS_o(SCSI_CS_o), .RE_o(RE_o), .WE_o(WE_o), .DACK_o(DACK_o), .S2F_o(S2F_o), .F2S_o(F2S_o),
    .S2CPU_o(S2CPU_o), .CPU2S_o(CPU2S_o), .LBYTE_(LBYTE_), .LS2CPU(LS2CPU), .INCBO_o(INCBO_o),
    .INCNI_o(INCNI_o), .INCNO_o(INCNO_o), .RIFIFO_o(RIFIFO_o), .RDFIFO_o(RDFIFO_o)
  );
  assign w_o = {SCSI_CS_o, RE_o, WE_o, DACK_o, S2F_o, F2S_o, S2CPU_o, CPU2S_o, LBYTE_, LS2CPU,
                INCBO_o, INCNI_o, INCNO_o, RIFIFO_o, RDFIFO_o};
  task automatic chk(input string tag, input logic [14:0] got, input logic [14:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic push(input string tag, input logic [14:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      q_tag.push_back(tag);
      q_exp.push_back(v);
    end
  endtask
  task automatic drain();
    while (q_exp.size() > 0) begin
      @(posedge CLK);
      #1;
      chk(q_tag.pop_front(), w_o, q_exp.pop_front());
    end
  endtask
  initial begin
    push("reset", IDL, 3);
    drain();
    RST = 1'b0;
    push("idle", IDL, 2);
    drain();
    CPUREQ = 1'b1; RW = 1'b1; AS_ = 1'b0;
    push("cpu_rd_stb", CS | RE | S2C | IDL, 3);
    push("cpu_rd_ack", S2C | LB, 3);
    drain();
    CPUREQ = 1'b0; AS_ = 1'b1;
    push("cpu_rd_rel", IDL, 2);
    drain();
    CPUREQ = 1'b1; RW = 1'b0; AS_ = 1'b0; DMADIR = 1'b1; DREQ_ = 1'b0;
    push("cpu_wr_stb", CS | WE | C2S | IDL, 3);
    push("cpu_wr_ack", LB, 2);
    drain();
    CPUREQ = 1'b0; AS_ = 1'b1;
    push("cpu_wr_rel", IDL, 1);
    push("dma_in_stb", DK | RE | S2F | IDL, 3);
    push("dma_in_lat", DK | S2F | LC | IBO, 1);
    drain();
    DREQ_ = 1'b1;
    push("dma_in_wait", IDL, 2);
    drain();
    BOEQ3 = 1'b1; DREQ_ = 1'b0;
    push("dma_bo3_stb", DK | RE | S2F | IDL, 3);
    push("dma_bo3_lat", DK | S2F | LC | IBO | INI, 1);
    push("rififo_hold", IDL | RIF, 4);
    drain();
    INCFIFO = 1'b1; DREQ_ = 1'b1;
    push("rififo_clr", IDL, 1);
    drain();
    INCFIFO = 1'b0;
    push("rififo_idle", IDL, 1);
    drain();
    DMADIR = 1'b0; FIFOEMPTY = 1'b1; BOEQ3 = 1'b0; DREQ_ = 1'b0;
    push("out_empty", IDL, 3);
    drain();
    FIFOEMPTY = 1'b0;
    push("dma_out_stb", DK | WE | F2S | IDL, 3);
    push("dma_out_lat", DK | F2S | IDL | IBO, 1);
    push("dma_out_wait", IDL, 1);
    drain();
    DREQ_ = 1'b1;
    push("dma_out_idle", IDL, 2);
    drain();
    BOEQ3 = 1'b1; DECFIFO = 1'b1; DREQ_ = 1'b0;
    push("out_bo3_stb", DK | WE | F2S | IDL, 3);
    push("out_bo3_lat", DK | F2S | IDL | IBO | INO, 1);
    drain();
    DREQ_ = 1'b1;
    push("rdfifo_pulse", IDL | RDF, 1);
    push("rdfifo_clr", IDL, 2);
    drain();
    DECFIFO = 1'b0; DMADIR = 1'b1; DREQ_ = 1'b0;
    push("pre_rst_stb", DK | RE | S2F | IDL, 2);
    drain();
    RST = 1'b1;
    push("rst_mid", IDL, 1);
    drain();
    RST = 1'b0; DREQ_ = 1'b1;
    push("post_rst", IDL, 2);
    drain();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/scsi_port_sm.md
Name: scsi_port_sm

Overview:
- Peripheral-side sequencer of the SCSI DMA controller; drives the WD33C93A strobes (chip select, read, write, DMA acknowledge).
- Serves two request types. The first is CPU register accesses to the SCSI chip (CPUREQ). The second is DMA byte transfers between the SCSI chip and the 32-bit FIFO (DREQ_).
- Steers the datapath muxes and handshakes FIFO pointer updates with the CPU-side state machine.
- Sits between the register block, FIFO, datapath and CPU bus state machine.

Parameters:
- STROBE_CYC, 3, number of CLK cycles RE_o/WE_o stay asserted per access (min 2).

Ports:
- CLK  in  1  system clock (only clock); all logic on its rising edge.
- RST  in  1  synchronous, active-high reset.
- CPUREQ  in  1  CPU requests a WD33C93 register access.
- RW  in  1  CPU bus direction: 1 = read from SCSI chip, 0 = write.
- AS_  in  1  CPU address strobe, active low.
- DMADIR  in  1  1 = SCSI to FIFO (to memory), 0 = FIFO to SCSI.
- DREQ_  in  1  DMA request from SCSI chip, active low, already gated by DMA enable.
- FIFOFULL  in  1  FIFO full.
- FIFOEMPTY  in  1  FIFO empty.
- BOEQ3  in  1  FIFO byte offset = 3 (last byte of the longword).
- INCFIFO  in  1  ack from CPU SM: FIFO count incremented.
- DECFIFO  in  1  ack from CPU SM: FIFO count decremented.
- SCSI_CS_o, RE_o, WE_o, DACK_o  out  1 each  active-high chip select, read strobe, write strobe, DMA ack.
- S2F_o, F2S_o, S2CPU_o, CPU2S_o  out  1 each  datapath steering: SCSI→FIFO, FIFO→SCSI, SCSI→CPU, CPU→SCSI.
- LBYTE_  out  1  active-low one-cycle byte latch into FIFO.
- LS2CPU  out  1  active-low; low = read data latched / cycle acknowledge to CPU.
- INCBO_o, INCNI_o, INCNO_o  out  1 each  one-cycle pulses: advance byte offset, next-in pointer, next-out pointer.
- RIFIFO_o, RDFIFO_o  out  1 each  level requests to the CPU SM to increment/decrement the FIFO count.

Behaviour:
- Reset:
  - State = IDLE.
  - All outputs 0, except LBYTE_ = 1 and LS2CPU = 1.
  - Reset mid-cycle aborts immediately; outputs take reset values on the next edge.
- States: IDLE, CPU_STB, CPU_ACK, DMA_STB, DMA_LATCH, DMA_WAIT.
- IDLE arbitration:
  - If CPUREQ & ~AS_: go to CPU_STB. CPU has priority over DMA.
  - Else if ~DREQ_ & ((DMADIR & ~FIFOFULL) | (~DMADIR & ~FIFOEMPTY)): go to DMA_STB.
  - While RIFIFO_o or RDFIFO_o is pending, DMA is not started.
- CPU_STB (STROBE_CYC cycles):
  - SCSI_CS_o = 1.
  - RW = 1: RE_o = 1 and S2CPU_o = 1.
  - RW = 0: WE_o = 1 and CPU2S_o = 1.
  - Then go to CPU_ACK.
- CPU_ACK:
  - Strobes and CS drop. LS2CPU = 0. S2CPU_o holds for reads so data stays valid.
  - Stays until AS_ = 1 and CPUREQ = 0, then IDLE with LS2CPU back to 1.
- DMA_STB (STROBE_CYC cycles):
  - DACK_o = 1.
  - DMADIR = 1: RE_o = 1 and S2F_o = 1.
  - DMADIR = 0: WE_o = 1 and F2S_o = 1.
- DMA_LATCH (1 cycle):
  - DACK_o and the steer signal stay held; strobes drop.
  - DMADIR = 1: LBYTE_ = 0.
  - INCBO_o = 1.
  - If BOEQ3 = 1:
    - DMADIR = 1: INCNI_o = 1 and RIFIFO_o is set.
    - DMADIR = 0: INCNO_o = 1 and RDFIFO_o is set.
- DMA_WAIT:
  - DACK_o = 0.
  - Returns to IDLE once DREQ_ has been sampled high or one cycle has elapsed. This guarantees at least one idle cycle between DACK pulses.
- FIFO handshake:
  - RIFIFO_o stays 1 until INCFIFO = 1 is sampled, then clears on the next edge.
  - RDFIFO_o clears the same way on DECFIFO = 1.
  - An ack arriving in the same cycle as the set is honoured, so the request is a one-cycle pulse.
- Boundaries:
  - FIFOFULL or FIFOEMPTY blocks a new DMA start only; it never aborts a cycle already in progress.
  - CPUREQ arriving during a DMA cycle waits for IDLE.
  - DREQ_ rising mid-strobe does not shorten the cycle.
- Output encoding: all outputs are decoded from the registered state, so they are glitch-free.

Decomposition:
- Shared package: state enum, and STROBE_CYC default as a localparam-compatible constant.
- Single module with a small strobe-cycle counter inline; no sub-module.

Test Plan:
- Reset: hold RST = 1 for 3 cycles → all outputs 0, LBYTE_ = 1, LS2CPU = 1, state IDLE.
- CPU read: CPUREQ = 1, RW = 1, AS_ = 0 → SCSI_CS_o = RE_o = S2CPU_o = 1 for 3 cycles; then LS2CPU = 0 until AS_ = 1 and CPUREQ = 0; then back to 1.
- CPU write while DREQ_ = 0: CPUREQ wins → WE_o = CPU2S_o = 1 for 3 cycles, DACK_o stays 0; the DMA cycle starts only after return to IDLE.
- DMA in: DMADIR = 1, DREQ_ = 0, BOEQ3 = 1 → DACK_o for 4 cycles, RE_o for 3, one LBYTE_ = 0 pulse, INCBO_o and INCNI_o pulses; RIFIFO_o = 1 until INCFIFO pulse, no new DACK before that.
- DMA out, FIFO empty: DMADIR = 0, DREQ_ = 0, FIFOEMPTY = 1 → no DACK; drop FIFOEMPTY → WE_o/F2S_o 3 cycles, INCBO_o pulse, no INCNO_o when BOEQ3 = 0.
- Reset mid-DMA: assert RST during DMA_STB → next edge all strobes 0, LBYTE_ = 1, no pointer pulses.
